vote_tally_n: RTL and testbench

VOTE_TALLY_N -- requirements
Module: vote_tally_n

---
 rtl/vote_tally_n.sv | 134 +++++++++++++
 tb/tb_vote_tally_n.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally_n.sv
// vote_tally_n: debounced one-vote-per-press tally with result display, leader and tie flags.
//   clock      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   mode       : 0 = voting, 1 = result/display
//   button     : one level input per candidate
//   sel        : candidate shown on led in result mode
//   clear      : zero all tallies (result mode only)
//   led        : all ones while a vote is counted (voting) or count[sel] (result)
//   vote_valid : one-cycle pulse per accepted vote
//   vote_err   : one-cycle pulse per rejected multi-button press
//   winner     : lowest index among the leading candidates (registered)
//   tie        : two or more candidates share a nonzero maximum (registered)
module vote_tally_n #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 10,
    localparam int CAND_W  = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] button,
    input  logic [CAND_W-1:0]   sel,
    input  logic                clear,
    output logic [CNT_W-1:0]    led,
    output logic                vote_valid,
    output logic                vote_err,
    output logic [CAND_W-1:0]   winner,
    output logic                tie
);
    typedef enum logic [1:0] {IDLE, ARMED, COUNTED, REJECT} state_t;

    state_t            r_state, w_state_nx;
    logic [7:0]        r_hold, w_hold_nx;
    logic [CAND_W-1:0] r_idx, w_idx, w_idx_nx;
    logic [CNT_W-1:0]  r_count [NUM_CAND];
    logic              r_vote_valid, r_vote_err, r_tie;
    logic [CAND_W-1:0] r_winner;
    logic              w_vote, w_err, w_single, w_multi, w_same, w_tie;
    logic [CNT_W-1:0]  w_max, w_led;
    logic [CAND_W-1:0] w_win;

    // clearing the lowest set bit leaves something only when two or more bits are high
    assign w_multi  = |(button & (button - NUM_CAND'(1)));
    assign w_single = |button && !w_multi;
    assign w_same   = button == (NUM_CAND'(1) << r_idx);

    always_comb begin
        w_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--)
            if (button[i]) w_idx = CAND_W'(i);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_idx        <= '0;
            r_vote_valid <= 1'b0;
            r_vote_err   <= 1'b0;
            r_winner     <= '0;
            r_tie        <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) r_count[i] <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_hold       <= w_hold_nx;
            r_idx        <= w_idx_nx;
            r_vote_valid <= w_vote;
            r_vote_err   <= w_err;
            r_winner     <= w_win;
            r_tie        <= w_tie;
            for (int i = 0; i < NUM_CAND; i++)
                if (mode && clear) r_count[i] <= '0;
                else if (w_vote && r_idx == CAND_W'(i) && r_count[i] != '1) r_count[i] <= r_count[i] + CNT_W'(1);
        end
    end

    // result mode overrides everything and drops any press in progress
    always_comb begin
        w_state_nx = r_state;
        w_hold_nx  = r_hold;
        w_idx_nx   = r_idx;
        w_vote     = 1'b0;
        w_err      = 1'b0;
        if (mode) begin
            w_state_nx = IDLE;
            w_hold_nx  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nx = w_single ? ARMED : w_multi ? REJECT : IDLE;
                    w_hold_nx  = w_single ? 8'd1 : 8'd0;
                    w_idx_nx   = w_single ? w_idx : r_idx;
                    w_err      = w_multi;
                end
                ARMED: begin
                    w_vote     = w_same && r_hold + 8'd1 == 8'(HOLD_CYC);
                    w_err      = w_multi;
                    w_state_nx = w_vote ? COUNTED : w_same ? ARMED : w_multi ? REJECT : IDLE;
                    w_hold_nx  = (w_same && !w_vote) ? r_hold + 8'd1 : 8'd0;
                end
                default: w_state_nx = |button ? r_state : IDLE;
            endcase
        end
    end

    always_comb begin
        w_led = '0;
        for (int i = 0; i < NUM_CAND; i++)
            if (sel == CAND_W'(i)) w_led = r_count[i];
        w_led = mode ? w_led : (r_state == COUNTED) ? '1 : '0;
    end

    // strict '>' keeps the lowest index when counts are equal
    always_comb begin
        w_max = '0;
        w_win = '0;
        w_tie = 1'b0;
        for (int i = 0; i < NUM_CAND; i++)
            if (r_count[i] > w_max) begin
                w_max = r_count[i];
                w_win = CAND_W'(i);
                w_tie = 1'b0;
            end else if (r_count[i] == w_max && w_max != '0) begin
                w_tie = 1'b1;
            end
    end

    assign led        = w_led;
    assign vote_valid = r_vote_valid;
    assign vote_err   = r_vote_err;
    assign winner     = r_winner;
    assign tie        = r_tie;
endmodule

// File: tb/tb_vote_tally_n.sv
// tb_vote_tally_n: directed self-checking bench for vote_tally_n at default parameters.
module tb_vote_tally_n;
    logic       clock = 1'b0, reset_n = 1'b0, mode = 1'b0, clear = 1'b0;
    logic [3:0] button = '0;
    logic [1:0] sel = '0;
    logic [7:0] led;
    logic       vote_valid, vote_err, tie;
    logic [1:0] winner;
    int         n_tests = 0, n_fail = 0;

    vote_tally_n dut (
        .clock(clock), .reset_n(reset_n), .mode(mode), .button(button), .sel(sel),
        .clear(clear), .led(led), .vote_valid(vote_valid), .vote_err(vote_err),
        .winner(winner), .tie(tie)
    );

    always #5 clock = ~clock;

    task automatic peek(input int s, output logic [7:0] v);
        logic m;
        m = mode;
        mode = 1'b1;
        sel = 2'(s);
        #1 v = led;
        mode = m;
    endtask

    task automatic press(input logic [3:0] b, input int n, output int vv, output int ve);
        button = b;
        vv = 0;
        ve = 0;
        repeat (n) begin
            @(negedge clock);
            vv += int'(vote_valid);
            ve += int'(vote_err);
        end
        button = '0;
        repeat (2) begin
            @(negedge clock);
            vv += int'(vote_valid);
            ve += int'(vote_err);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({led, vote_valid, vote_err, winner, tie} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got led=%h vv=%b ve=%b win=%0d tie=%b, expected all 0", led, vote_valid, vote_err, winner, tie);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_first_vote();
        int vv = 0;
        button = 4'b0001;
        repeat (10) begin
            @(negedge clock);
            vv += int'(vote_valid);
        end
        n_tests++;
        if (vv !== 1) begin n_fail++; $display("FAIL first_vote_pulse: got %0d pulses, expected 1", vv); end
        n_tests++;
        if (led !== 8'hFF) begin n_fail++; $display("FAIL counted_led: got %h, expected ff", led); end
        button = '0;
        @(negedge clock);
        n_tests++;
        if ({led, vote_valid} !== 9'd0) begin n_fail++; $display("FAIL idle_led: got led=%h vv=%b, expected 00 0", led, vote_valid); end
        mode = 1'b1;
        sel = 2'd0;
        repeat (2) @(negedge clock);
        n_tests++;
        if ({led, winner, tie} !== {8'h01, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL result_c0: got led=%h win=%0d tie=%b, expected 01 0 0", led, winner, tie);
        end
        mode = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_short_press();
        int vv, ve;
        logic [7:0] v;
        press(4'b0010, 9, vv, ve);
        peek(1, v);
        n_tests++;
        if ({vv[7:0], v} !== 16'd0) begin n_fail++; $display("FAIL short_press: got vv=%0d count1=%h, expected 0 00", vv, v); end
        press(4'b0010, 300, vv, ve);
        peek(1, v);
        n_tests++;
        if (vv !== 1 || v !== 8'h01) begin n_fail++; $display("FAIL long_hold: got vv=%0d count1=%h, expected 1 01", vv, v); end
        n_tests++;
        if ({winner, tie} !== {2'd0, 1'b1}) begin n_fail++; $display("FAIL tie_c0_c1: got win=%0d tie=%b, expected 0 1", winner, tie); end
    endtask

    task automatic test_reject();
        int vv = 0, ve = 0;
        logic [7:0] v1, v2;
        button = 4'b0110;
        repeat (5) begin
            @(negedge clock);
            vv += int'(vote_valid);
            ve += int'(vote_err);
        end
        button = 4'b0010;
        repeat (15) begin
            @(negedge clock);
            vv += int'(vote_valid);
            ve += int'(vote_err);
        end
        button = '0;
        repeat (2) @(negedge clock);
        n_tests++;
        if (ve !== 1 || vv !== 0) begin n_fail++; $display("FAIL reject_pulses: got ve=%0d vv=%0d, expected 1 0", ve, vv); end
        peek(1, v1);
        peek(2, v2);
        n_tests++;
        if ({v1, v2} !== 16'h0100) begin n_fail++; $display("FAIL reject_counts: got c1=%h c2=%h, expected 01 00", v1, v2); end
        press(4'b0010, 10, vv, ve);
        n_tests++;
        if (vv !== 1 || ve !== 0) begin n_fail++; $display("FAIL after_reject: got vv=%0d ve=%0d, expected 1 0", vv, ve); end
    endtask

    task automatic test_winner();
        int vv, ve;
        press(4'b1000, 10, vv, ve);
        press(4'b1000, 10, vv, ve);
        n_tests++;
        if ({winner, tie} !== {2'd1, 1'b1}) begin n_fail++; $display("FAIL tie_c1_c3: got win=%0d tie=%b, expected 1 1", winner, tie); end
        button = 4'b1000;
        repeat (10) @(negedge clock);
        n_tests++;
        if ({vote_valid, winner, tie} !== {1'b1, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL winner_lag: got vv=%b win=%0d tie=%b, expected 1 1 1", vote_valid, winner, tie);
        end
        button = '0;
        @(negedge clock);
        n_tests++;
        if ({winner, tie} !== {2'd3, 1'b0}) begin n_fail++; $display("FAIL winner_c3: got win=%0d tie=%b, expected 3 0", winner, tie); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_mode_clear();
        int vv = 0;
        logic [7:0] v0, v1, v3;
        button = 4'b0100;
        repeat (5) @(negedge clock);
        mode = 1'b1;
        repeat (15) begin
            @(negedge clock);
            vv += int'(vote_valid);
        end
        button = '0;
        @(negedge clock);
        mode = 1'b0;
        repeat (2) begin
            @(negedge clock);
            vv += int'(vote_valid);
        end
        peek(2, v0);
        n_tests++;
        if (vv !== 0 || v0 !== 8'h00) begin n_fail++; $display("FAIL mode_abort: got vv=%0d c2=%h, expected 0 00", vv, v0); end
        clear = 1'b1;
        repeat (2) @(negedge clock);
        clear = 1'b0;
        peek(1, v1);
        peek(3, v3);
        n_tests++;
        if ({v1, v3} !== 16'h0203) begin n_fail++; $display("FAIL clear_mode0: got c1=%h c3=%h, expected 02 03", v1, v3); end
        mode = 1'b1;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        peek(0, v0);
        peek(1, v1);
        peek(3, v3);
        n_tests++;
        if ({v0, v1, v3} !== 24'd0) begin n_fail++; $display("FAIL clear_mode1: got c0=%h c1=%h c3=%h, expected 00 00 00", v0, v1, v3); end
        @(negedge clock);
        n_tests++;
        if ({winner, tie} !== 3'd0) begin n_fail++; $display("FAIL clear_winner: got win=%0d tie=%b, expected 0 0", winner, tie); end
        mode = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_saturate();
        int vv, ve, tv = 0, te = 0;
        logic [7:0] v;
        for (int k = 0; k < 255; k++) begin
            press(4'b0100, 10, vv, ve);
            tv += vv;
            te += ve;
        end
        peek(2, v);
        n_tests++;
        if (tv !== 255 || te !== 0 || v !== 8'hFF) begin
            n_fail++;
            $display("FAIL fill_255: got vv=%0d ve=%0d c2=%h, expected 255 0 ff", tv, te, v);
        end
        press(4'b0100, 10, vv, ve);
        peek(2, v);
        n_tests++;
        if (vv !== 1 || v !== 8'hFF) begin n_fail++; $display("FAIL saturate: got vv=%0d c2=%h, expected 1 ff", vv, v); end
        n_tests++;
        if ({winner, tie} !== {2'd2, 1'b0}) begin n_fail++; $display("FAIL winner_c2: got win=%0d tie=%b, expected 2 0", winner, tie); end
    endtask

    task automatic test_async_reset();
        int vv = 0;
        logic [7:0] v;
        button = 4'b0001;
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({led, vote_valid, vote_err, winner, tie} !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset: got led=%h vv=%b ve=%b win=%0d tie=%b, expected all 0", led, vote_valid, vote_err, winner, tie);
        end
        peek(2, v);
        n_tests++;
        if (v !== 8'h00) begin n_fail++; $display("FAIL reset_count: got c2=%h, expected 00", v); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (9) begin
            @(negedge clock);
            vv += int'(vote_valid);
        end
        n_tests++;
        if (vv !== 0) begin n_fail++; $display("FAIL press_discarded: got %0d pulses after 9 cycles, expected 0", vv); end
        @(negedge clock);
        n_tests++;
        if (vote_valid !== 1'b1) begin n_fail++; $display("FAIL new_press: got vv=%b on 10th cycle, expected 1", vote_valid); end
        button = '0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_first_vote();
        test_short_press();
        test_reject();
        test_winner();
        test_mode_clear();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
